// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the board master and the register slave.
// Signal names match the original flat port list.
interface axi_lite_reg_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: scratch, control, write counter and ID word,
// with LEDs driven from scratch when the control enable bit is set.
module axi_lite_reg_slave #(
   parameter int unsigned C_S_AXI_ACLK_FREQ_HZ = 100000000,
   parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH   = 32,
   parameter logic [31:0] C_ID                 = 32'hDF20_0001
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   axi_lite_reg_slave_if.slave  s_axi,
   output logic [7:0]           LEDS
);
   localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W = DW / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic          aw_ready, w_ready, b_valid, w_fire;
   logic          ar_ready, r_valid, r_fire;
   logic [1:0]    b_resp, r_resp;
   logic [DW-1:0] r_data;
   logic [DW-1:0] scratch, ctrl, wcount;
   logic [7:0]    leds_q;

   logic          w_oor, r_oor;
   logic [1:0]    w_sel, r_sel;
   logic [DW-1:0] rd_word;
   logic [1:0]    rd_resp;

   logic [31:0]   unused_freq;
   logic [3:0]    unused_addr_lsbs;
   assign unused_freq      = C_S_AXI_ACLK_FREQ_HZ[31:0];
   assign unused_addr_lsbs = {s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [STRB_W-1:0] strb);
      logic [DW-1:0] m;
      m = old_v;
      for (int unsigned i = 0; i < STRB_W; i++) begin
         if (strb[i]) m[8*i +: 8] = new_v[8*i +: 8];
      end
      return m;
   endfunction

   // ---------------- write channel ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) w_state <= W_IDLE;
      else                w_state <= w_next;
   end

   always_comb begin
      w_next   = w_state;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      w_fire   = 1'b0;
      case (w_state)
         W_IDLE: begin
            // AW and W are only ever taken together
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) w_next = W_ACCEPT;
         end
         W_ACCEPT: begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            w_fire   = 1'b1;
            w_next   = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign w_oor = |s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign w_sel = s_axi.S_AXI_AWADDR[3:2];

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         scratch <= '0;
         ctrl    <= '0;
         wcount  <= '0;
         b_resp  <= RESP_OKAY;
      end else if (w_fire) begin
         wcount <= wcount + 1'b1;
         if (w_oor || w_sel[1]) begin
            b_resp <= RESP_SLVERR;
         end else begin
            b_resp <= RESP_OKAY;
            if (w_sel[0]) ctrl    <= merge_bytes(ctrl, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
            else          scratch <= merge_bytes(scratch, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
         end
      end
   end

   // ---------------- read channel ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) r_state <= R_IDLE;
      else                r_state <= r_next;
   end

   always_comb begin
      r_next   = r_state;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      r_fire   = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (s_axi.S_AXI_ARVALID) r_next = R_ACCEPT;
         end
         R_ACCEPT: begin
            ar_ready = 1'b1;
            r_fire   = 1'b1;
            r_next   = R_RESP;
         end
         R_RESP: begin
            r_valid = 1'b1;
            if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign r_oor = |s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign r_sel = s_axi.S_AXI_ARADDR[3:2];

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_SLVERR;
      if (!r_oor) begin
         rd_resp = RESP_OKAY;
         case (r_sel)
            2'd0:    rd_word = scratch;
            2'd1:    rd_word = ctrl;
            2'd2:    rd_word = wcount;
            default: rd_word = C_ID;
         endcase
      end
   end

   // Sampled from the pre-edge registers, so a same-edge write is not visible
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_data <= '0;
         r_resp <= RESP_OKAY;
      end else if (r_fire) begin
         r_data <= rd_word;
         r_resp <= rd_resp;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) leds_q <= '0;
      else                leds_q <= ctrl[0] ? scratch[7:0] : 8'h00;
   end

   assign s_axi.S_AXI_AWREADY = aw_ready;
   assign s_axi.S_AXI_WREADY  = w_ready;
   assign s_axi.S_AXI_BVALID  = b_valid;
   assign s_axi.S_AXI_BRESP   = b_resp;
   assign s_axi.S_AXI_ARREADY = ar_ready;
   assign s_axi.S_AXI_RVALID  = r_valid;
   assign s_axi.S_AXI_RDATA   = r_data;
   assign s_axi.S_AXI_RRESP   = r_resp;
   assign LEDS                = leds_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: hand-derived expectations flow through a
// scoreboard queue, pushed when a transaction is issued and popped at its response.
module tb_axi_lite_reg_slave;
   localparam logic [31:0] ID = 32'hDF20_0001;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] leds;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;
   exp_t exp_q[$];

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic [7:0]  exp_leds;
   } op_t;

   axi_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_reg_slave #(
      .C_S_AXI_ACLK_FREQ_HZ(100000000),
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(32),
      .C_ID(ID)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rstn),
      .s_axi(bus),
      .LEDS(leds)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int n;
      @(negedge clk);
      bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20);
      if (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY)) begin
         n_cmp++; n_bad++;
         $display("FAIL write_accept_timeout addr=%h got no AWREADY/WREADY, required within 20 cycles", a);
         bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; resp = 2'bxx;
         return;
      end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
      n = 0;
      while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
      if (!bus.S_AXI_BVALID) begin
         n_cmp++; n_bad++;
         $display("FAIL bvalid_timeout addr=%h got BVALID=0, required 1 within 20 cycles", a);
         bus.S_AXI_BREADY = 1'b0; resp = 2'bxx;
         return;
      end
      resp = bus.S_AXI_BRESP;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus.S_AXI_ARREADY && n < 20);
      if (!bus.S_AXI_ARREADY) begin
         n_cmp++; n_bad++;
         $display("FAIL read_accept_timeout addr=%h got no ARREADY, required within 20 cycles", a);
         bus.S_AXI_ARVALID = 1'b0; d = 'x; resp = 2'bxx;
         return;
      end
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
      n = 0;
      while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
      if (!bus.S_AXI_RVALID) begin
         n_cmp++; n_bad++;
         $display("FAIL rvalid_timeout addr=%h got RVALID=0, required 1 within 20 cycles", a);
         bus.S_AXI_RREADY = 1'b0; d = 'x; resp = 2'bxx;
         return;
      end
      d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; exp_t e;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
           bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl_outputs got %b, required 0", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                  bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP});
      end
      n_cmp++;
      if ({bus.S_AXI_RDATA, leds} !== 40'h0) begin
         n_bad++;
         $display("FAIL reset_data_outputs got rdata=%h leds=%h, required 0/0", bus.S_AXI_RDATA, leds);
      end
      rstn = 1'b1;
      exp_q.push_back('{data: ID, resp: 2'b00});
      do_read(32'hC, d, r);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d, r} !== {e.data, e.resp}) begin
         n_bad++;
         $display("FAIL reset_id_read got %h/%b, required %h/%b", d, r, e.data, e.resp);
      end
   endtask

   task automatic test_register_map();
      op_t ops[10];
      logic [31:0] d; logic [1:0] r; exp_t e;
      ops[0] = '{1'b1, 32'h0, 32'hA5A5_1234, 4'hF, 32'h0,         2'b00, 8'h00};
      ops[1] = '{1'b1, 32'h4, 32'h0000_0001, 4'hF, 32'h0,         2'b00, 8'h34};
      ops[2] = '{1'b0, 32'h0, 32'h0,         4'h0, 32'hA5A5_1234, 2'b00, 8'h34};
      ops[3] = '{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0002, 2'b00, 8'h34};
      ops[4] = '{1'b1, 32'h0, 32'h1122_3344, 4'hF, 32'h0,         2'b00, 8'h44};
      ops[5] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 4'h5, 32'h0,         2'b00, 8'hFF};
      ops[6] = '{1'b0, 32'h0, 32'h0,         4'h0, 32'h11FF_33FF, 2'b00, 8'hFF};
      ops[7] = '{1'b1, 32'h4, 32'hABCD_00FF, 4'hA, 32'h0,         2'b00, 8'hFF};
      ops[8] = '{1'b0, 32'h7, 32'h0,         4'h0, 32'hAB00_0001, 2'b00, 8'hFF};
      ops[9] = '{1'b0, 32'h9, 32'h0,         4'h0, 32'h0000_0005, 2'b00, 8'hFF};
      foreach (ops[i]) begin
         exp_q.push_back('{data: ops[i].exp_data, resp: ops[i].exp_resp});
         if (ops[i].wr) begin
            do_write(ops[i].addr, ops[i].data, ops[i].strb, r);
            e = exp_q.pop_front();
            n_cmp++;
            if (r !== e.resp) begin
               n_bad++;
               $display("FAIL map_bresp[%0d] got %b, required %b", i, r, e.resp);
            end
         end else begin
            do_read(ops[i].addr, d, r);
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, r} !== {e.data, e.resp}) begin
               n_bad++;
               $display("FAIL map_read[%0d] addr=%h got %h/%b, required %h/%b", i, ops[i].addr, d, r, e.data, e.resp);
            end
         end
         n_cmp++;
         if (leds !== ops[i].exp_leds) begin
            n_bad++;
            $display("FAIL map_leds[%0d] got %h, required %h", i, leds, ops[i].exp_leds);
         end
      end
   endtask

   task automatic test_errors();
      op_t ops[10];
      logic [31:0] d; logic [1:0] r; exp_t e;
      ops[0] = '{1'b1, 32'h8,         32'hDEAD_BEEF, 4'hF, 32'h0,         2'b10, 8'hFF};
      ops[1] = '{1'b1, 32'hC,         32'h0,         4'hF, 32'h0,         2'b10, 8'hFF};
      ops[2] = '{1'b1, 32'h10,        32'h0,         4'hF, 32'h0,         2'b10, 8'hFF};
      ops[3] = '{1'b1, 32'h8000_0000, 32'h0,         4'hF, 32'h0,         2'b10, 8'hFF};
      ops[4] = '{1'b0, 32'h8,         32'h0,         4'h0, 32'h0000_0009, 2'b00, 8'hFF};
      ops[5] = '{1'b0, 32'h0,         32'h0,         4'h0, 32'h11FF_33FF, 2'b00, 8'hFF};
      ops[6] = '{1'b0, 32'h4,         32'h0,         4'h0, 32'hAB00_0001, 2'b00, 8'hFF};
      ops[7] = '{1'b0, 32'hC,         32'h0,         4'h0, ID,            2'b00, 8'hFF};
      ops[8] = '{1'b0, 32'h100,       32'h0,         4'h0, 32'h0,         2'b10, 8'hFF};
      ops[9] = '{1'b0, 32'h8000_000C, 32'h0,         4'h0, 32'h0,         2'b10, 8'hFF};
      foreach (ops[i]) begin
         exp_q.push_back('{data: ops[i].exp_data, resp: ops[i].exp_resp});
         if (ops[i].wr) begin
            do_write(ops[i].addr, ops[i].data, ops[i].strb, r);
            e = exp_q.pop_front();
            n_cmp++;
            if (r !== e.resp) begin
               n_bad++;
               $display("FAIL err_bresp[%0d] addr=%h got %b, required %b", i, ops[i].addr, r, e.resp);
            end
         end else begin
            do_read(ops[i].addr, d, r);
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, r} !== {e.data, e.resp}) begin
               n_bad++;
               $display("FAIL err_read[%0d] addr=%h got %h/%b, required %h/%b", i, ops[i].addr, d, r, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_backpressure_b();
      int n; logic [31:0] d; logic [1:0] r; exp_t e;
      logic [31:0] raddr[2];
      @(negedge clk);
      bus.S_AXI_AWADDR = 32'h0; bus.S_AXI_WDATA = 32'hCAFE_0001; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
      exp_q.push_back('{data: 32'h0, resp: 2'b00});
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 20);
      n_cmp++;
      if (bus.S_AXI_AWREADY !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_b_first_accept got AWREADY=%b, required 1", bus.S_AXI_AWREADY);
      end
      @(negedge clk);
      bus.S_AXI_WDATA = 32'hBEEF_0002;
      exp_q.push_back('{data: 32'h0, resp: 2'b00});
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.S_AXI_BRESP !== e.resp) begin
         n_bad++;
         $display("FAIL bp_b_first_bresp got %b, required %b", bus.S_AXI_BRESP, e.resp);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin
            n_bad++;
            $display("FAIL bp_b_hold[%0d] got BVALID/AWREADY/WREADY=%b, required 100", i,
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
         end
         @(negedge clk);
      end
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b00) begin
         n_bad++;
         $display("FAIL bp_b_release got BVALID/AWREADY=%b, required 00", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b11) begin
         n_bad++;
         $display("FAIL bp_b_second_accept got AWREADY/WREADY=%b, required 11", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
      end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP} !== {1'b1, e.resp}) begin
         n_bad++;
         $display("FAIL bp_b_second_resp got %b/%b, required 1/%b", bus.S_AXI_BVALID, bus.S_AXI_BRESP, e.resp);
      end
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      raddr[0] = 32'h0; raddr[1] = 32'h8;
      exp_q.push_back('{data: 32'hBEEF_0002, resp: 2'b00});
      exp_q.push_back('{data: 32'd11,        resp: 2'b00});
      foreach (raddr[i]) begin
         do_read(raddr[i], d, r);
         e = exp_q.pop_front();
         n_cmp++;
         if ({d, r} !== {e.data, e.resp}) begin
            n_bad++;
            $display("FAIL bp_b_read[%0d] got %h/%b, required %h/%b", i, d, r, e.data, e.resp);
         end
      end
   endtask

   task automatic test_backpressure_r();
      int n; logic [31:0] d; logic [1:0] r; exp_t e, ew;
      @(negedge clk);
      bus.S_AXI_ARADDR = 32'h0; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
      exp_q.push_back('{data: 32'hBEEF_0002, resp: 2'b00});
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < 20);
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      e = exp_q.pop_front();
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            // write channel keeps running while the read response is stalled
            exp_q.push_back('{data: 32'h0, resp: 2'b00});
            do_write(32'h0, 32'h5555_AAAA, 4'hF, r);
            ew = exp_q.pop_front();
            n_cmp++;
            if (r !== ew.resp) begin
               n_bad++;
               $display("FAIL bp_r_side_write got %b, required %b", r, ew.resp);
            end
         end
         n_cmp++;
         if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA, bus.S_AXI_RRESP} !== {2'b10, e.data, e.resp}) begin
            n_bad++;
            $display("FAIL bp_r_hold[%0d] got RVALID=%b ARREADY=%b RDATA=%h RRESP=%b, required 1/0/%h/%b", i,
                     bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA, bus.S_AXI_RRESP, e.data, e.resp);
         end
         @(negedge clk);
      end
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      n_cmp++;
      if (bus.S_AXI_RVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_r_release got RVALID=%b, required 0", bus.S_AXI_RVALID);
      end
      exp_q.push_back('{data: 32'h5555_AAAA, resp: 2'b00});
      do_read(32'h0, d, r);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d, r, leds} !== {e.data, e.resp, 8'hAA}) begin
         n_bad++;
         $display("FAIL bp_r_after got %h/%b leds=%h, required %h/%b leds=aa", d, r, leds, e.data, e.resp);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d, d2; logic [1:0] rw, rr, r2; exp_t ew, er;
      exp_q.push_back('{data: 32'h0,         resp: 2'b00});
      exp_q.push_back('{data: 32'h5555_AAAA, resp: 2'b00});
      fork
         do_write(32'h0, 32'h0F0F_0F0F, 4'hF, rw);
         do_read(32'h0, d, rr);
      join
      ew = exp_q.pop_front();
      er = exp_q.pop_front();
      n_cmp++;
      if (rw !== ew.resp) begin
         n_bad++;
         $display("FAIL simul_bresp got %b, required %b", rw, ew.resp);
      end
      n_cmp++;
      if ({d, rr} !== {er.data, er.resp}) begin
         n_bad++;
         $display("FAIL simul_read_old got %h/%b, required %h/%b", d, rr, er.data, er.resp);
      end
      exp_q.push_back('{data: 32'h0F0F_0F0F, resp: 2'b00});
      do_read(32'h0, d2, r2);
      er = exp_q.pop_front();
      n_cmp++;
      if ({d2, r2} !== {er.data, er.resp}) begin
         n_bad++;
         $display("FAIL simul_read_new got %h/%b, required %h/%b", d2, r2, er.data, er.resp);
      end
   endtask

   task automatic test_wcount_wrap();
      op_t ops[6];
      logic [31:0] d; logic [1:0] r; exp_t e;
      @(negedge clk);
      force dut.wcount = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.wcount;
      ops[0] = '{1'b0, 32'h8, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'b00, 8'h0F};
      ops[1] = '{1'b1, 32'h4, 32'h0000_0001, 4'hF, 32'h0,         2'b00, 8'h0F};
      ops[2] = '{1'b0, 32'h8, 32'h0,         4'h0, 32'h0,         2'b00, 8'h0F};
      ops[3] = '{1'b0, 32'h4, 32'h0,         4'h0, 32'h0000_0001, 2'b00, 8'h0F};
      ops[4] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, 8'h0F};
      ops[5] = '{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0001, 2'b00, 8'h0F};
      foreach (ops[i]) begin
         exp_q.push_back('{data: ops[i].exp_data, resp: ops[i].exp_resp});
         if (ops[i].wr) begin
            do_write(ops[i].addr, ops[i].data, ops[i].strb, r);
            e = exp_q.pop_front();
            n_cmp++;
            if (r !== e.resp) begin
               n_bad++;
               $display("FAIL wrap_bresp[%0d] got %b, required %b", i, r, e.resp);
            end
         end else begin
            do_read(ops[i].addr, d, r);
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, r} !== {e.data, e.resp}) begin
               n_bad++;
               $display("FAIL wrap_read[%0d] addr=%h got %h/%b, required %h/%b", i, ops[i].addr, d, r, e.data, e.resp);
            end
         end
         n_cmp++;
         if (leds !== ops[i].exp_leds) begin
            n_bad++;
            $display("FAIL wrap_leds[%0d] got %h, required %h", i, leds, ops[i].exp_leds);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n; logic [31:0] d; logic [1:0] r; exp_t e;
      logic [31:0] raddr[3];
      @(negedge clk);
      bus.S_AXI_AWADDR = 32'h0; bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 20);
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      n_cmp++;
      if (bus.S_AXI_BVALID !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_pending got BVALID=%b, required 1", bus.S_AXI_BVALID);
      end
      rstn = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_BRESP, leds} !== 12'h0) begin
         n_bad++;
         $display("FAIL rstmid_cleared got BVALID=%b AWREADY=%b BRESP=%b LEDS=%h, required all 0",
                  bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_BRESP, leds);
      end
      rstn = 1'b1;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      n_cmp++;
      if (bus.S_AXI_BVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_dropped got BVALID=%b, required 0", bus.S_AXI_BVALID);
      end
      raddr[0] = 32'h0; raddr[1] = 32'h4; raddr[2] = 32'h8;
      foreach (raddr[i]) exp_q.push_back('{data: 32'h0, resp: 2'b00});
      foreach (raddr[i]) begin
         do_read(raddr[i], d, r);
         e = exp_q.pop_front();
         n_cmp++;
         if ({d, r} !== {e.data, e.resp}) begin
            n_bad++;
            $display("FAIL rstmid_read[%0d] addr=%h got %h/%b, required %h/%b", i, raddr[i], d, r, e.data, e.resp);
         end
      end
   endtask

   initial begin
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
      test_reset();
      test_register_map();
      test_errors();
      test_backpressure_b();
      test_backpressure_r();
      test_simultaneous();
      test_wcount_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
